// File: rtl/store_unit.sv
// Store sequencer: decodes funct3/addr into byte strobes, flags faulting stores,
// and drives a req/ack write handshake with the data memory under a timeout.
module store_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wrbits,
    input  logic        mem_ack,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wrbits_q, wrbits_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [2:0]         funct3;
    logic [3:0]         dec_wrbits;
    logic               dec_misal;
    logic               dec_illegal;
    logic               unused_ir;

    assign funct3    = ir[14:12];
    assign unused_ir = ^{ir[31:15], ir[11:0]};

    always_comb begin
        dec_wrbits  = 4'b0000;
        dec_misal   = 1'b0;
        dec_illegal = 1'b0;
        case (funct3)
            3'b000: dec_wrbits = 4'b0001 << addr[1:0];
            3'b001: begin
                dec_wrbits = addr[1] ? 4'b1100 : 4'b0011;
                dec_misal  = addr[0];
            end
            3'b010: begin
                dec_wrbits = 4'b1111;
                dec_misal  = (addr[1:0] != 2'b00);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wrbits_d = wrbits_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = {addr[31:2], 2'b00};
                    wdata_d  = wdata;
                    wrbits_d = dec_wrbits;
                    cnt_d    = '0;
                    if (dec_illegal) begin
                        code_d  = 2'b10;
                        state_d = ERR;
                    end else if (dec_misal) begin
                        code_d  = 2'b01;
                        state_d = ERR;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // ack takes priority over the final timeout cycle
                if (mem_ack) begin
                    state_d = DONE;
                end else if (cnt_q == TMO_LAST) begin
                    code_d  = 2'b11;
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wrbits_q <= '0;
            code_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wrbits_q <= wrbits_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wrbits = (state_q == REQ) ? wrbits_q : 4'b0000;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = (state_q == ERR);
    assign err_code   = (state_q == ERR) ? code_q : 2'b00;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: transaction-level model checked every cycle,
// plus hand-computed latency/strobe/error-code expectations per scenario.
module tb_store_unit;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_req, busy, done, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wrbits;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .addr(addr),
        .wdata(wdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wrbits(mem_wrbits), .mem_ack(mem_ack),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {fault code, strobes} straight from the store-width rules
    function automatic logic [5:0] spec_decode(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            3'd0:    return {2'b00, 4'((32'd1) << lo)};
            3'd1:    return {(lo[0] ? 2'b01 : 2'b00), (lo[1] ? 4'b1100 : 4'b0011)};
            3'd2:    return {((lo != 2'b00) ? 2'b01 : 2'b00), 4'b1111};
            default: return {2'b10, 4'b0000};
        endcase
    endfunction

    // Transaction model: what phase of a store the bench believes we are in
    typedef enum {P_IDLE, P_REQ, P_DONE, P_ERR} phase_t;
    phase_t      ph = P_IDLE;
    int          n_req = 0;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_wb = '0;
    logic [1:0]  m_code = '0;
    logic [5:0]  dec;

    assign dec = spec_decode(ir[14:12], addr[1:0]);

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph <= P_IDLE;
            n_req <= 0;
        end else begin
            case (ph)
                P_IDLE: if (start) begin
                    m_addr  <= addr & 32'hFFFF_FFFC;
                    m_wdata <= wdata;
                    m_wb    <= dec[3:0];
                    m_code  <= dec[5:4];
                    n_req   <= 0;
                    ph      <= (dec[5:4] != 2'b00) ? P_ERR : P_REQ;
                end
                P_REQ: begin
                    n_req <= n_req + 1;
                    if (mem_ack) ph <= P_DONE;
                    else if (n_req + 1 == TIMEOUT) begin
                        ph     <= P_ERR;
                        m_code <= 2'b11;
                    end
                end
                default: ph <= P_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        chk("mem_req", 32'(mem_req), 32'(ph == P_REQ));
        chk("mem_wrbits", 32'(mem_wrbits), 32'((ph == P_REQ) ? m_wb : 4'b0000));
        chk("busy", 32'(busy), 32'(ph != P_IDLE));
        chk("done", 32'(done), 32'(ph == P_DONE));
        chk("err", 32'(err), 32'(ph == P_ERR));
        chk("err_code", 32'(err_code), 32'((ph == P_ERR) ? m_code : 2'b00));
        if (ph == P_REQ) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    // Launch one store; latencies are counted in cycles after the start edge.
    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int ack_after, input bit poke,
                             output int t_done, output int t_err, output int nreq,
                             output logic [31:0] c_addr, output logic [3:0] c_wb,
                             output logic [1:0] c_code);
        bit ended;
        t_done = -1; t_err = -1; nreq = 0; c_addr = 'x; c_wb = 'x; c_code = 'x;
        ended = 1'b0;
        @(posedge clock); #1;
        ir = {17'h0, f3, 5'h0, 7'h23}; addr = a; wdata = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin t_done = c; ended = 1'b1; break; end
            if (err)  begin t_err = c; c_code = err_code; ended = 1'b1; break; end
            mem_ack = 1'b0;
            start   = 1'b0;
            if (mem_req) begin
                if (nreq == 0) begin c_addr = mem_addr; c_wb = mem_wrbits; end
                if (poke && nreq == 1) begin
                    start = 1'b1; ir = 32'h0000_0023; addr = 32'hFFFF_FFF1; wdata = 32'h0;
                end
                mem_ack = (nreq == ack_after);
                nreq++;
            end
            @(posedge clock); #1;
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (!ended) chk("completion_timeout", 32'd0, 32'd1);
    endtask

    int          td, te, nr;
    logic [31:0] ca;
    logic [3:0]  cw;
    logic [1:0]  cc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b1;

        // 1: SW aligned, ack one cycle after req
        run_store(3'b010, 32'h100, 32'hDEAD_BEEF, 1, 1'b0, td, te, nr, ca, cw, cc);
        chk("t1_done_lat", td, 3);
        chk("t1_no_err", te, -1);
        chk("t1_addr", ca, 32'h100);
        chk("t1_wrbits", 32'(cw), 32'hF);

        // 2: SB to top byte, ack in first REQ cycle
        run_store(3'b000, 32'h103, 32'h5A5A_5A5A, 0, 1'b0, td, te, nr, ca, cw, cc);
        chk("t2_done_lat", td, 2);
        chk("t2_wrbits", 32'(cw), 32'h8);
        chk("t2_addr", ca, 32'h100);

        // 3: SH upper half ok, SH odd address faults
        run_store(3'b001, 32'h102, 32'h1234_1234, 0, 1'b0, td, te, nr, ca, cw, cc);
        chk("t3_done_lat", td, 2);
        chk("t3_wrbits", 32'(cw), 32'hC);
        run_store(3'b001, 32'h101, 32'h1234_1234, 0, 1'b0, td, te, nr, ca, cw, cc);
        chk("t3_err_lat", te, 1);
        chk("t3_err_code", 32'(cc), 32'h1);
        chk("t3_no_req", nr, 0);

        // 4: illegal funct3, misaligned SW
        run_store(3'b011, 32'h100, 32'h0, 0, 1'b0, td, te, nr, ca, cw, cc);
        chk("t4_illegal_code", 32'(cc), 32'h2);
        chk("t4_illegal_lat", te, 1);
        run_store(3'b010, 32'h2, 32'h0, 0, 1'b0, td, te, nr, ca, cw, cc);
        chk("t4_misal_code", 32'(cc), 32'h1);

        // 5: timeout, then ack on the last allowed cycle
        run_store(3'b010, 32'h200, 32'hCAFE_F00D, -1, 1'b0, td, te, nr, ca, cw, cc);
        chk("t5_req_cycles", nr, 16);
        chk("t5_err_lat", te, 17);
        chk("t5_err_code", 32'(cc), 32'h3);
        @(posedge clock); #1;
        chk("t5_busy_drop", 32'(busy), 32'd0);
        run_store(3'b010, 32'h204, 32'h0BAD_CAFE, 15, 1'b0, td, te, nr, ca, cw, cc);
        chk("t5b_done_lat", td, 17);
        chk("t5b_no_err", te, -1);
        chk("t5b_req_cycles", nr, 16);

        // start pulse during DONE is ignored
        start = 1'b1; ir = 32'h0000_2023; addr = 32'h400;
        @(posedge clock); #1;
        start = 1'b0;
        chk("done_start_ignored", 32'(busy), 32'd0);

        // ack while idle is ignored
        mem_ack = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        mem_ack = 1'b0;

        // 6: start pokes during REQ must not disturb the latched store
        run_store(3'b010, 32'h108, 32'h1111_2222, 3, 1'b1, td, te, nr, ca, cw, cc);
        chk("t6_poke_done_lat", td, 5);
        chk("t6_poke_addr", ca, 32'h108);

        // reset in the middle of REQ
        @(posedge clock); #1;
        ir = 32'h0000_2023; addr = 32'h500; wdata = 32'h7777_7777; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("t6_in_req", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_wrbits", 32'(mem_wrbits), 32'd0);
        chk("t6_rst_addr", mem_addr, 32'd0);
        chk("t6_rst_wdata", mem_wdata, 32'd0);
        chk("t6_rst_done_err", 32'({done, err}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        run_store(3'b010, 32'h300, 32'h8888_9999, 1, 1'b0, td, te, nr, ca, cw, cc);
        chk("t6_after_rst_done", td, 3);
        chk("t6_after_rst_addr", ca, 32'h300);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
